fm_frag_reader: RTL and testbench
=================================

Name: fm_frag_reader

Overview:
- Read-side sequencer for the fragment-memory (FM) ping-pong buffer.
- Waits until the FM writer reports a full buffer, pulses the buffer-swap request, then sweeps a signed fragment index over the newly readable buffer.
- Each padded fragment returned by the FM is registered and presented on a valid/ready stream to the downstream hashing stage.
- Sits between the FM buffer (drives its change-index and fragment-index inputs) and the MinHash datapath.

Parameters:
- BUF_BASES, 32, bases per FM buffer.
- FRAG_BASES, 8, bases per fragment.
- DATA_BITS, 2, bits per base.
- FRAG_LEN, 16, fragment width in bits (FRAG_BASES*DATA_BITS).
- IDX_LEN, 6, signed fragment index width ($clog2(BUF_BASES)+1), two's complement.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- fm_wait  in  1  FM writer holding: write buffer full, awaiting swap.
- fm_rdata  in  FRAG_LEN  padded fragment from FM, combinational from fm_frag_idx.
- fm_chg_idx  out  1  one-cycle swap request to FM.
- fm_frag_idx  out  IDX_LEN  signed fragment start index to FM.
- frag_valid  out  1  output fragment valid.
- frag_ready  in  1  downstream accept.
- frag_data  out  FRAG_LEN  registered fragment.
- frag_pos  out  IDX_LEN  signed index that produced frag_data.
- frag_last  out  1  marks the final fragment of a sweep.
- busy  out  1  high in every state except WAIT_FULL.

Behaviour:
- Reset (async on rst rising, held while high): state=WAIT_FULL. All of fm_chg_idx, fm_frag_idx, frag_valid, frag_data, frag_pos, frag_last and busy are 0.
- Sweep range: START=-(FRAG_BASES-1)=-7, END=BUF_BASES-FRAG_BASES=24, stride 1, giving 32 fragments per sweep.
- Index arithmetic: idx is a signed IDX_LEN-bit value, incremented by 1, and never exceeds END (no wrap).
- WAIT_FULL: fm_chg_idx=0, fm_frag_idx=0. Sampling fm_wait=1 moves to SWAP.
- SWAP: fm_chg_idx=1 for exactly this cycle; idx<=START; next state SWEEP.
- SWEEP:
  - fm_frag_idx=idx.
  - A load occurs when (!frag_valid || frag_ready). On load: frag_data<=fm_rdata, frag_pos<=idx, frag_last<=(idx==END), frag_valid<=1.
  - On a load with idx==END go to DRAIN; on any other load, idx<=idx+1.
  - With no load, idx and fm_frag_idx hold.
- DRAIN: no loads. When frag_valid&&frag_ready, frag_valid<=0 and the state goes to WAIT_FULL.
- The WAIT_FULL check then runs the cycle after the last fragment is accepted. If fm_wait is already 1, SWAP follows immediately: 1 idle cycle between sweeps.
- Latency: fm_wait high sampled at edge k gives fm_chg_idx high in cycle k+1 and the first frag_valid high after edge k+2. With frag_ready=1, throughput is 1 fragment/cycle.
- Handshake: while frag_valid&&!frag_ready, frag_data, frag_pos and frag_last stay stable. There is no drop and no duplicate.
- fm_chg_idx is never asserted outside SWAP. In particular it is never asserted while fm_wait=0, so the FM write address is never disturbed mid-fill.
- Negative indices: FM zero-pads the low 2*|idx| bits. This block passes the data through unmodified.
- Reset mid-sweep: the partial sweep is abandoned. After release the block waits for fm_wait again. The FM is reset by the same domain.

Optional Feature:
- Macro: FM_RD_SKIP_PAD_EN.
- Defined: START=0, so zero-padded leading fragments are skipped. A sweep is 25 fragments (pos 0..24) and SWAP loads idx<=0.
- Undefined: START=-(FRAG_BASES-1), 32 fragments per sweep, as above.

Test Plan:
- Reset and idle: assert rst, hold fm_wait=0 for 100 cycles -> all outputs 0 throughout, fm_chg_idx never asserted.
- Full sweep: FM model buffer bases b[n]=n%4, fm_wait rises at cycle 10, frag_ready=1 -> fm_chg_idx high at cycle 11 only. 32 consecutive fragments follow with pos -7..24.
  - pos -7: bits[13:0]=0 and bits[15:14]=b[0].
  - pos 24: frag_last=1 and data equals b[24..31].
- Backpressure: frag_ready pattern 1,0,0,1,0,1... -> every pos -7..24 seen exactly once, in order. Data, pos and last stay stable while stalled.
- Back-to-back: fm_wait held 1 through sweep end -> the next fm_chg_idx pulse occurs 2 cycles after the last-fragment accept, and a second sweep of 32 follows.
- Reset mid-sweep: assert rst after pos 5 is accepted -> frag_valid=0 and busy=0 immediately. After release, no output until fm_wait=1; the new sweep restarts at pos -7.
- Macro: with FM_RD_SKIP_PAD_EN defined, repeat the full sweep -> 25 fragments, pos 0..24, last on 24.

Source files
------------

// File: rtl/fm_frag_reader.sv
// fm_frag_reader: FM ping-pong read sequencer; define FM_RD_SKIP_PAD_EN to skip zero-padded leading fragments
module fm_frag_reader #(
  parameter int BUF_BASES  = 32,
  parameter int FRAG_BASES = 8,
  parameter int DATA_BITS  = 2,
  parameter int FRAG_LEN   = FRAG_BASES * DATA_BITS,
  parameter int IDX_LEN    = $clog2(BUF_BASES) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fm_wait,
  input  logic [FRAG_LEN-1:0]        fm_rdata,
  output logic                       fm_chg_idx,
  output logic signed [IDX_LEN-1:0]  fm_frag_idx,
  output logic                       frag_valid,
  input  logic                       frag_ready,
  output logic [FRAG_LEN-1:0]        frag_data,
  output logic signed [IDX_LEN-1:0]  frag_pos,
  output logic                       frag_last,
  output logic                       busy
);
`ifdef FM_RD_SKIP_PAD_EN
  localparam logic signed [IDX_LEN-1:0] IDX_START = '0;
`else
  localparam logic signed [IDX_LEN-1:0] IDX_START = IDX_LEN'(-(FRAG_BASES - 1));
`endif
  localparam logic signed [IDX_LEN-1:0] IDX_END = IDX_LEN'(BUF_BASES - FRAG_BASES);
  typedef enum logic [1:0] {WAIT_FULL, SWAP, SWEEP, DRAIN} state_t;
  state_t state, nxt;
  logic signed [IDX_LEN-1:0] idx;
  logic load, at_end, accept;
  assign load   = (state == SWEEP) && (!frag_valid || frag_ready);
  assign at_end = idx == IDX_END;
  assign accept = frag_valid && frag_ready;
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_FULL;
    else     state <= nxt;
  end
  // next state: idle until full, one swap cycle, sweep, then drain the final fragment
  always_comb begin
    nxt = state == WAIT_FULL ? (fm_wait ? SWAP : WAIT_FULL) :
          state == SWAP      ? SWEEP :
          state == SWEEP     ? (load && at_end ? DRAIN : SWEEP) :
                               (accept ? WAIT_FULL : DRAIN);
  end
  // outputs decoded from state; the FM only sees a live index while sweeping
  always_comb begin
    fm_chg_idx  = state == SWAP;
    fm_frag_idx = state == SWEEP ? idx : '0;
    busy        = state != WAIT_FULL;
  end
  // sweep index and registered output stage; holds while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      frag_valid <= 1'b0;
      frag_data  <= '0;
      frag_pos   <= '0;
      frag_last  <= 1'b0;
    end else begin
      if (state == SWAP)         idx <= IDX_START;
      else if (load && !at_end)  idx <= idx + IDX_LEN'(1);
      if (load) begin
        frag_data  <= fm_rdata;
        frag_pos   <= idx;
        frag_last  <= at_end;
        frag_valid <= 1'b1;
      end else if (state == DRAIN && accept) begin
        frag_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fm_frag_reader.sv
// tb_fm_frag_reader: vector table plus random backpressure against a fragment-sequence model
module tb_fm_frag_reader;
  localparam int NB = 32, FB = 8, FL = 16, IL = 6;
`ifdef FM_RD_SKIP_PAD_EN
  localparam int START = 0;
`else
  localparam int START = -(FB - 1);
`endif
  localparam int LAST = NB - FB;
  localparam int NF = LAST - START + 1;
  typedef struct {
    int pct; int nsw;
    int exp_frags; int exp_chg; int exp_chg_off; int exp_val_off; int exp_gap; int exp_span;
  } vec_t;
  logic clk = 0, rst = 1, fm_wait = 0, frag_ready = 0;
  logic [FL-1:0] fm_rdata, frag_data;
  logic fm_chg_idx, frag_valid, frag_last, busy;
  logic signed [IL-1:0] fm_frag_idx, frag_pos;
  logic [2*NB-1:0] buf_v = '0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  fm_frag_reader dut (
    .clk(clk), .rst(rst), .fm_wait(fm_wait), .fm_rdata(fm_rdata),
    .fm_chg_idx(fm_chg_idx), .fm_frag_idx(fm_frag_idx), .frag_valid(frag_valid),
    .frag_ready(frag_ready), .frag_data(frag_data), .frag_pos(frag_pos),
    .frag_last(frag_last), .busy(busy)
  );
  always_comb begin
    fm_rdata = '0;
    for (int j = 0; j < FB; j++) begin
      int p;
      p = int'($signed(fm_frag_idx)) + j;
      if (p >= 0 && p < NB) fm_rdata[2*j +: 2] = buf_v[2*p +: 2];
    end
  end
  function automatic logic [FL-1:0] exp_frag(input int pos);
    logic [2*NB+2*(FB-1)-1:0] pad;
    pad = {buf_v, {(2*(FB-1)){1'b0}}};
    return pad[2*(pos+FB-1) +: FL];
  endfunction
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic run_sweep(input int pct, input int nsw, output int frags, output int chg,
                           output int chg_off, output int val_off, output int gap, output int span);
    int ep, sw, last_t, first_t;
    bit pv, pr;
    logic [FL-1:0] pd;
    logic signed [IL-1:0] pp;
    logic pl;
    ep = START; sw = 0; last_t = -1; first_t = -1;
    frags = 0; chg = 0; chg_off = -1; val_off = -1; gap = -1; span = -1;
    pv = 0; pr = 0; pd = '0; pp = '0; pl = 0;
    fm_wait = 1;
    for (int t = 1; t <= 4000; t++) begin
      @(posedge clk); #1;
      if (fm_chg_idx) begin
        chk("chg_wait_high", fm_wait, 1);
        chg++;
        if (chg_off < 0) chg_off = t;
        if (last_t >= 0 && gap < 0) gap = t - last_t;
        if (chg >= nsw) fm_wait = 0;
      end
      if (frag_valid && val_off < 0) val_off = t;
      if (pv && !pr) chk("stall_hold", {frag_valid, frag_data, frag_pos, frag_last}, {1'b1, pd, pp, pl});
      frag_ready = $urandom_range(99) < pct;
      if (frag_valid && frag_ready) begin
        chk("pos", frag_pos, ep);
        chk("data", frag_data, exp_frag(ep));
        chk("last", frag_last, ep == LAST);
        frags++;
        if (first_t < 0) first_t = t;
        if (ep == LAST) begin
          sw++;
          if (span < 0) span = t - first_t;
          last_t = t;
          ep = START;
        end else ep++;
      end
      pv = frag_valid; pr = frag_ready; pd = frag_data; pp = frag_pos; pl = frag_last;
      if (sw == nsw && t >= last_t + 6) break;
    end
    checks++;
    if (sw != nsw) begin
      errors++;
      $display("FAIL sweep_timeout: got %0d sweeps expected %0d", sw, nsw);
    end
    chk("idle_after", {frag_valid, busy, fm_chg_idx}, 0);
    frag_ready = 0;
  endtask
  initial begin
    vec_t vecs[5];
    int frags, chg, chg_off, val_off, gap, span;
    bit found;
    vecs[0] = '{100, 1, NF,   1, 1, 3, -1, NF-1};
    vecs[1] = '{40,  1, NF,   1, 1, 3, -1, -1};
    vecs[2] = '{100, 2, 2*NF, 2, 1, 3, 2,  NF-1};
    vecs[3] = '{70,  2, 2*NF, 2, 1, 3, 2,  -1};
    vecs[4] = '{15,  1, NF,   1, 1, 3, -1, -1};
    repeat (3) @(posedge clk);
    #1 chk("in_reset", {fm_chg_idx, fm_frag_idx, frag_valid, frag_data, frag_pos, frag_last, busy}, 0);
    @(negedge clk) rst = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      chk("idle", {fm_chg_idx, fm_frag_idx, frag_valid, frag_data, frag_pos, frag_last, busy}, 0);
    end
    for (int n = 0; n < NB; n++) buf_v[2*n +: 2] = 2'(n % 4);
    fm_wait = 1;
    frag_ready = 1;
    found = 0;
    for (int t = 0; t < 200 && !found; t++) begin
      @(posedge clk); #1;
      if (fm_chg_idx) fm_wait = 0;
      if (frag_valid && frag_pos == 5) begin
        @(posedge clk); #1;
        found = 1;
      end
    end
    chk("mid_reset_reach_pos5", found, 1);
    rst = 1;
    #1 chk("mid_reset_out", {frag_valid, busy, fm_chg_idx}, 0);
    @(negedge clk) rst = 0;
    frag_ready = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("post_reset_idle", {frag_valid, busy, fm_chg_idx}, 0);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) buf_v = {$urandom, $urandom};
      run_sweep(vecs[i].pct, vecs[i].nsw, frags, chg, chg_off, val_off, gap, span);
      chk("frags", frags, vecs[i].exp_frags);
      chk("chg_pulses", chg, vecs[i].exp_chg);
      chk("chg_latency", chg_off, vecs[i].exp_chg_off);
      chk("valid_latency", val_off, vecs[i].exp_val_off);
      chk("b2b_gap", gap, vecs[i].exp_gap);
      if (vecs[i].exp_span >= 0) chk("throughput_span", span, vecs[i].exp_span);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
